// File: rtl/vect_collect.sv
// vect_collect: receive side of the chunked vector transfer link.
//
// Accepts P-element chunks (one per in_valid && in_ready cycle), stores them
// in order into a V-element vector, then offers the vector downstream with a
// vector_valid / vector_ack handshake.
//
// If the transmitter ends a frame early (in_done before the last chunk), the
// partial frame is dropped and short_err pulses for one cycle.
//
// Ports:
//   clk          - clock; all logic is on the rising edge
//   reset        - synchronous, active-high reset
//   in_valid     - in_vals carries a new chunk this cycle
//   in_vals      - incoming chunk; element j of chunk k goes to vector[k*P+j]
//   in_done      - end-of-frame pulse from the transmitter
//   in_ready     - collector can accept a chunk (COLLECT state, not in reset)
//   vector       - assembled vector (held stable while vector_valid)
//   vector_valid - vector is complete
//   vector_ack   - downstream has consumed the vector
//   short_err    - one-cycle pulse: frame ended before V elements arrived
//   frame_cnt    - number of completed vectors, wraps at 2^16
module vect_collect #(
  parameter int V   = 4,
  parameter int P   = 2,
  parameter int BIT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [P-1:0][BIT-1:0] in_vals,
  input  logic                  in_done,
  output logic                  in_ready,
  output logic [V-1:0][BIT-1:0] vector,
  output logic                  vector_valid,
  input  logic                  vector_ack,
  output logic                  short_err,
  output logic [15:0]           frame_cnt
);

  // Index counts accepted elements; one extra bit so V itself is representable.
  localparam int IW     = $clog2(V) + 1;
  localparam int NCHUNK = V / P;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_FULL    = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           index_q, index_d;
  logic [V-1:0][BIT-1:0]   vector_q, vector_d;
  logic                    vector_valid_q, vector_valid_d;
  logic                    short_err_q, short_err_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  logic                    accept_s;
  logic                    last_chunk_s;

  // in_ready is decoded from state; held low while reset is applied.
  assign in_ready     = (state_q == S_COLLECT) && !reset;
  assign accept_s     = in_valid && (state_q == S_COLLECT);
  assign last_chunk_s = (index_q == IW'(V - P));

  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign short_err    = short_err_q;
  assign frame_cnt    = frame_cnt_q;

  // Chunk write: only the slot addressed by index is loaded on accept.
  // Comparing against constant chunk bases keeps every select in range.
  always_comb begin
    vector_d = vector_q;
    for (int c = 0; c < NCHUNK; c++) begin
      for (int j = 0; j < P; j++) begin
        if (accept_s && (index_q == IW'(c * P))) begin
          vector_d[c*P + j] = in_vals[j];
        end else begin
          vector_d[c*P + j] = vector_q[c*P + j];
        end
      end
    end
  end

  // Next-state logic for the COLLECT/FULL handshake, index and status flags.
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    vector_valid_d = vector_valid_q;
    short_err_d    = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    case (state_q)
      S_COLLECT: begin
        if (accept_s) begin
          if (last_chunk_s) begin
            // Final chunk wins over a coincident in_done: normal completion.
            state_d        = S_FULL;
            vector_valid_d = 1'b1;
            index_d        = {IW{1'b0}};
            frame_cnt_d    = frame_cnt_q + 16'd1;
          end else if (in_done) begin
            // Chunk is stored but the frame is short; start over.
            index_d     = {IW{1'b0}};
            short_err_d = 1'b1;
          end else begin
            index_d = index_q + IW'(P);
          end
        end else if (in_done && (index_q != {IW{1'b0}})) begin
          index_d     = {IW{1'b0}};
          short_err_d = 1'b1;
        end else begin
          // Idle, or the normal trailing done after a completed frame.
          index_d = index_q;
        end
      end
      S_FULL: begin
        // in_valid and in_done are ignored here; only ack releases the vector.
        if (vector_ack) begin
          state_d        = S_COLLECT;
          vector_valid_d = 1'b0;
        end else begin
          state_d        = S_FULL;
          vector_valid_d = 1'b1;
        end
      end
      default: begin
        state_d        = S_COLLECT;
        vector_valid_d = 1'b0;
        index_d        = {IW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_COLLECT;
      index_q        <= {IW{1'b0}};
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
      short_err_q    <= 1'b0;
      frame_cnt_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      short_err_q    <= short_err_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_vect_collect.sv
// Table-driven bench for vect_collect (V=4, P=2, BIT=32). Each row drives one
// cycle of inputs and lists the outputs expected just after that rising edge.
module tb_vect_collect;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [1:0][31:0]  in_vals;
  logic              in_done;
  logic              in_ready;
  logic [3:0][31:0]  vector;
  logic              vector_valid;
  logic              vector_ack;
  logic              short_err;
  logic [15:0]       frame_cnt;

  int n_vec;
  int n_err;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        done;
    logic        ack;
    logic        rdy;
    logic        vv;
    logic        se;
    logic [15:0] fc;
    logic        chk;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] e3;
  } row_t;

  row_t tbl[$];

  vect_collect #(.V(4), .P(2), .BIT(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_vals      (in_vals),
    .in_done      (in_done),
    .in_ready     (in_ready),
    .vector       (vector),
    .vector_valid (vector_valid),
    .vector_ack   (vector_ack),
    .short_err    (short_err),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(input logic rst, input logic iv, input logic [31:0] a0,
                              input logic [31:0] a1, input logic done, input logic ack,
                              input logic rdy, input logic vv, input logic se,
                              input logic [15:0] fc, input logic chk,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    row_t r;
    r.rst = rst; r.iv = iv; r.a0 = a0; r.a1 = a1; r.done = done; r.ack = ack;
    r.rdy = rdy; r.vv = vv; r.se = se; r.fc = fc; r.chk = chk;
    r.e0 = e0; r.e1 = e1; r.e2 = e2; r.e3 = e3;
    return r;
  endfunction

  task automatic apply(input row_t r, input string tag);
    logic [127:0] exp_vec;
    @(negedge clk);
    reset      = r.rst;
    in_valid   = r.iv;
    in_vals[0] = r.a0;
    in_vals[1] = r.a1;
    in_done    = r.done;
    vector_ack = r.ack;
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== r.rdy) begin
      n_err++;
      $display("FAIL %s in_ready: got %b want %b", tag, in_ready, r.rdy);
    end
    if (vector_valid !== r.vv) begin
      n_err++;
      $display("FAIL %s vector_valid: got %b want %b", tag, vector_valid, r.vv);
    end
    if (short_err !== r.se) begin
      n_err++;
      $display("FAIL %s short_err: got %b want %b", tag, short_err, r.se);
    end
    if (frame_cnt !== r.fc) begin
      n_err++;
      $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, r.fc);
    end
    exp_vec = {r.e3, r.e2, r.e1, r.e0};
    if (r.chk && (vector !== exp_vec)) begin
      n_err++;
      $display("FAIL %s vector: got %h want %h", tag, vector, exp_vec);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_vals    = '0;
    in_done    = 1'b0;
    vector_ack = 1'b0;

    //              rst   iv    a0     a1     done  ack   rdy   vv    se    fc      chk   e0     e1     e2     e3
    // Reset state.
    tbl.push_back(mk(1'b1,1'b0,32'h0, 32'h0, 1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b1,1'b0,32'h0, 32'h0, 1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0));
    // Basic frame: {11,22},{33,44}.
    tbl.push_back(mk(1'b0,1'b1,32'h11,32'h22,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd0, 1'b1, 32'h11,32'h22,32'h0, 32'h0));
    tbl.push_back(mk(1'b0,1'b1,32'h33,32'h44,1'b0,1'b0, 1'b0,1'b1,1'b0,16'd1, 1'b1, 32'h11,32'h22,32'h33,32'h44));
    // Held in FULL for 5 cycles while the transmitter keeps pushing {AA,BB}.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b0,1'b1,32'hAA,32'hBB,1'b0,1'b0, 1'b0,1'b1,1'b0,16'd1, 1'b1, 32'h11,32'h22,32'h33,32'h44));
    // Ack releases; in_ready back next cycle, vector contents untouched.
    tbl.push_back(mk(1'b0,1'b0,32'h0, 32'h0, 1'b0,1'b1, 1'b1,1'b0,1'b0,16'd1, 1'b1, 32'h11,32'h22,32'h33,32'h44));
    // Short frame: one chunk then in_done alone.
    tbl.push_back(mk(1'b0,1'b1,32'h5, 32'h6, 1'b0,1'b0, 1'b1,1'b0,1'b0,16'd1, 1'b1, 32'h5, 32'h6, 32'h33,32'h44));
    tbl.push_back(mk(1'b0,1'b0,32'h0, 32'h0, 1'b1,1'b0, 1'b1,1'b0,1'b1,16'd1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0,1'b0,32'h0, 32'h0, 1'b0,1'b0, 1'b1,1'b0,1'b0,16'd1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0));
    // Next frame restarts at element 0.
    tbl.push_back(mk(1'b0,1'b1,32'h7, 32'h8, 1'b0,1'b0, 1'b1,1'b0,1'b0,16'd1, 1'b1, 32'h7, 32'h8, 32'h33,32'h44));
    tbl.push_back(mk(1'b0,1'b1,32'h9, 32'hA, 1'b0,1'b0, 1'b0,1'b1,1'b0,16'd2, 1'b1, 32'h7, 32'h8, 32'h9, 32'hA));
    tbl.push_back(mk(1'b0,1'b0,32'h0, 32'h0, 1'b0,1'b1, 1'b1,1'b0,1'b0,16'd2, 1'b1, 32'h7, 32'h8, 32'h9, 32'hA));
    // Trailing done with index 0: no effect.
    tbl.push_back(mk(1'b0,1'b0,32'h0, 32'h0, 1'b1,1'b0, 1'b1,1'b0,1'b0,16'd2, 1'b1, 32'h7, 32'h8, 32'h9, 32'hA));
    // Done with a non-final chunk: chunk stored, frame short.
    tbl.push_back(mk(1'b0,1'b1,32'hC1,32'hC2,1'b1,1'b0, 1'b1,1'b0,1'b1,16'd2, 1'b1, 32'hC1,32'hC2,32'h9, 32'hA));
    tbl.push_back(mk(1'b0,1'b1,32'hD1,32'hD2,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd2, 1'b1, 32'hD1,32'hD2,32'h9, 32'hA));
    // Done with the final chunk: normal completion.
    tbl.push_back(mk(1'b0,1'b1,32'hD3,32'hD4,1'b1,1'b0, 1'b0,1'b1,1'b0,16'd3, 1'b1, 32'hD1,32'hD2,32'hD3,32'hD4));
    // Done while FULL is ignored.
    tbl.push_back(mk(1'b0,1'b0,32'h0, 32'h0, 1'b1,1'b0, 1'b0,1'b1,1'b0,16'd3, 1'b1, 32'hD1,32'hD2,32'hD3,32'hD4));
    tbl.push_back(mk(1'b0,1'b0,32'h0, 32'h0, 1'b0,1'b1, 1'b1,1'b0,1'b0,16'd3, 1'b1, 32'hD1,32'hD2,32'hD3,32'hD4));
    // Reset mid-frame drops the partial frame silently.
    tbl.push_back(mk(1'b0,1'b1,32'hE1,32'hE2,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd3, 1'b1, 32'hE1,32'hE2,32'hD3,32'hD4));
    tbl.push_back(mk(1'b1,1'b0,32'h0, 32'h0, 1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0,1'b1,32'h1, 32'h2, 1'b0,1'b0, 1'b1,1'b0,1'b0,16'd0, 1'b1, 32'h1, 32'h2, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0,1'b1,32'h3, 32'h4, 1'b0,1'b0, 1'b0,1'b1,1'b0,16'd1, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4));
    // Reset while FULL.
    tbl.push_back(mk(1'b1,1'b0,32'h0, 32'h0, 1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0));
    // Ack in COLLECT is ignored.
    tbl.push_back(mk(1'b0,1'b0,32'h0, 32'h0, 1'b0,1'b1, 1'b1,1'b0,1'b0,16'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0));

    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Back-to-back frames, ack asserted on the cycle vector_valid is seen high.
    for (int f = 0; f < 3; f++) begin
      logic [31:0] b;
      b = 32'h100 * (f + 1);
      apply(mk(1'b0,1'b1,b+32'd1,b+32'd2,1'b0,1'b0, 1'b1,1'b0,1'b0,16'(f),   1'b0, 32'h0,32'h0,32'h0,32'h0),
            $sformatf("b2b%0d_c0", f));
      apply(mk(1'b0,1'b1,b+32'd3,b+32'd4,1'b0,1'b0, 1'b0,1'b1,1'b0,16'(f+1), 1'b1, b+32'd1,b+32'd2,b+32'd3,b+32'd4),
            $sformatf("b2b%0d_c1", f));
      apply(mk(1'b0,1'b0,32'h0,32'h0,    1'b0,1'b1, 1'b1,1'b0,1'b0,16'(f+1), 1'b1, b+32'd1,b+32'd2,b+32'd3,b+32'd4),
            $sformatf("b2b%0d_ack", f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
